char_motion_ctrl: RTL and testbench
===================================

// Module: char_motion_ctrl
// PURPOSE
//  Character motion stage directly upstream of the pixel generator. Turns the
//  left/right/jump buttons into the char_abs_x/char_abs_y coordinates the
//  pixel generator consumes. Implements walk, charge-jump, airborne flight
//  with gravity, wall handling and landing, advancing once per game tick.
//  y is absolute map height, measured upward; Y_FLOOR is the map floor.
// PARAMETERS
//  PHY_WIDTH   14   width of position fields (unsigned); velocities are PHY_WIDTH+1 signed
//  X_MIN       130  leftmost char x (map offset + wall)
//  X_MAX       550  rightmost char x (map right wall - CHAR_WIDTH_X)
//  X_INIT      300  reset x
//  Y_FLOOR     10   floor height (MAP_Y_OFFSET + WALL_WIDTH); also the reset y
//  WALK_SPEED  2    px per tick while walking
//  JUMP_VX     3    |vx| per tick while airborne
//  VY_MIN      4    launch vy with zero charge
//  MAX_CHARGE  31   charge counter saturation value
//  GRAVITY     1    vy decrement per tick
//  MAX_FALL    15   terminal downward speed (vy >= -MAX_FALL)
// PORTS
//  sys_clk     in   1          system clock
//  sys_rst_n   in   1          asynchronous active-low reset
//  game_tick   in   1          1-cycle frame pulse; all motion updates happen on it
//  left_btn    in   1          raw button, async to sys_clk
//  right_btn   in   1          raw button
//  jump_btn    in   1          raw button
//  ground_hit  in   1          collision stage: char bottom rests on a platform
//  char_abs_x  out  PHY_WIDTH  character x
//  char_abs_y  out  PHY_WIDTH  character y
//  char_face   out  1          0 = left, 1 = right
//  char_state  out  2          0 IDLE, 1 CHARGE, 2 AIR, 3 LAND
//  charge_lvl  out  5          current charge (debug / sprite select)
// BEHAVIOUR
//  Clock/reset: single clock sys_clk; reset is asynchronous, active-low (sys_rst_n).
//  Reset (async, any time, including mid-jump): x=X_INIT, y=Y_FLOOR, vx=vy=0,
//    state IDLE, face=1, charge=0, synchronisers cleared.
//  Buttons: 2-flop synchroniser each, then sampled only on game_tick.
//  All outputs registered; a tick's effect is visible the cycle after game_tick.
//  Between ticks every register holds.
//  IDLE: L only -> x -= WALK_SPEED, face=0; R only -> x += WALK_SPEED, face=1;
//    L+R or none -> no move. x clamps to [X_MIN,X_MAX].
//    jump=1 -> CHARGE, charge=0, no move this tick.
//    ground_hit=0 and y>Y_FLOOR -> AIR with vx=0, vy=0 (walked off ledge).
//  CHARGE: x frozen; charge += 1 per tick, saturating at MAX_CHARGE; L/R only
//    update face. jump=0 -> AIR, vy=VY_MIN+charge, vx=-JUMP_VX if L only,
//    +JUMP_VX if R only, else 0; charge cleared.
//  AIR, per tick: x += vx, y += vy, then vy = max(vy-GRAVITY, -MAX_FALL).
//    x beyond X_MIN/X_MAX: clamp, and vx handled per CONFIGURATION.
//    vy<=0 and (ground_hit or y+vy<=Y_FLOOR): y=max(y+vy,Y_FLOOR), vx=vy=0 -> LAND.
//    y arithmetic is signed PHY_WIDTH+1; a negative result clamps to Y_FLOOR.
//  LAND: one tick, buttons ignored -> IDLE.
//  Priority within a tick: landing > wall > gravity.
// CONFIGURATION
//  CHAR_WALL_BOUNCE_EN defined: airborne wall contact negates vx (bounce) and
//    flips char_face. Not defined: airborne wall contact sets vx=0, face unchanged.
//  IDLE walking always clamps with no bounce in both builds.
// TESTING
//  1 Reset held, then released with no buttons -> x=300, y=10, state=0, face=1;
//    assert reset mid-AIR -> same values next cycle, without a clock edge needed.
//  2 R held 10 ticks -> x=320, face=1; L+R held 5 ticks -> x unchanged.
//  3 jump held 40 ticks -> charge_lvl saturates at 31, x frozen; release with R ->
//    AIR, vy=35, vx=+3, first tick y=45.
//  4 Zero-charge jump (press+release in 1 tick), no L/R -> apex y=20 (4+3+2+1);
//    returns to y=10, LAND for one tick, then IDLE.
//  5 x=548 R-jump -> x clamps 550; BOUNCE_EN: vx=-3 and face=0; else vx=0.
//  6 Ledge: ground_hit dropped at y=100 in IDLE -> AIR vy=0; vy never
//    below -15; ground_hit=1 during fall -> LAND at current y.

Source files
------------

// File: rtl/char_motion_ctrl_if.sv
// Game-side bundle for char_motion_ctrl: tick, buttons and collision in; character pose out.
// Master drives the inputs and reads the pose. Slave is the motion controller.
interface char_motion_ctrl_if #(
    parameter int PHY_WIDTH = 14
);
    logic                 game_tick;
    logic                 left_btn;
    logic                 right_btn;
    logic                 jump_btn;
    logic                 ground_hit;
    logic [PHY_WIDTH-1:0] char_abs_x;
    logic [PHY_WIDTH-1:0] char_abs_y;
    logic                 char_face;
    logic [1:0]           char_state;
    logic [4:0]           charge_lvl;

    modport master (
        output game_tick, left_btn, right_btn, jump_btn, ground_hit,
        input  char_abs_x, char_abs_y, char_face, char_state, charge_lvl
    );

    modport slave (
        input  game_tick, left_btn, right_btn, jump_btn, ground_hit,
        output char_abs_x, char_abs_y, char_face, char_state, charge_lvl
    );
endinterface

// File: rtl/char_motion_ctrl.sv
// Character motion: walk, charge-jump, gravity flight, wall handling and landing, one step per game_tick.
// Define CHAR_WALL_BOUNCE_EN to make airborne wall contact bounce (negate vx, flip face) instead of stopping.
module char_motion_ctrl #(
    parameter int PHY_WIDTH  = 14,
    parameter int X_MIN      = 130,
    parameter int X_MAX      = 550,
    parameter int X_INIT     = 300,
    parameter int Y_FLOOR    = 10,
    parameter int WALK_SPEED = 2,
    parameter int JUMP_VX    = 3,
    parameter int VY_MIN     = 4,
    parameter int MAX_CHARGE = 31,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 15
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    char_motion_ctrl_if.slave bus
);
    localparam int VW = PHY_WIDTH + 1;
    // Two spare bits so x+vx and y+vy can go out of range and be clamped instead of wrapping.
    localparam int AW = PHY_WIDTH + 2;

    localparam logic signed [AW-1:0] X_MIN_S   = AW'(X_MIN);
    localparam logic signed [AW-1:0] X_MAX_S   = AW'(X_MAX);
    localparam logic signed [AW-1:0] Y_FLOOR_S = AW'(Y_FLOOR);
    localparam logic signed [AW-1:0] WALK_S    = AW'(WALK_SPEED);
    localparam logic [PHY_WIDTH-1:0] X_MIN_U   = PHY_WIDTH'(X_MIN);
    localparam logic [PHY_WIDTH-1:0] X_MAX_U   = PHY_WIDTH'(X_MAX);
    localparam logic [PHY_WIDTH-1:0] X_INIT_U  = PHY_WIDTH'(X_INIT);
    localparam logic [PHY_WIDTH-1:0] Y_FLOOR_U = PHY_WIDTH'(Y_FLOOR);
    localparam logic signed [VW-1:0] JUMP_S    = VW'(JUMP_VX);
    localparam logic signed [VW-1:0] VY_MIN_S  = VW'(VY_MIN);
    localparam logic signed [VW-1:0] GRAV_S    = VW'(GRAVITY);
    localparam logic signed [VW-1:0] FALL_LIM  = VW'(-MAX_FALL);
    localparam logic [4:0]           CHARGE_MAX = 5'(MAX_CHARGE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHARGE = 2'd1,
        S_AIR    = 2'd2,
        S_LAND   = 2'd3
    } state_t;

    function automatic logic [PHY_WIDTH-1:0] clamp_x(input logic signed [AW-1:0] v);
        if (v < X_MIN_S) return X_MIN_U;
        if (v > X_MAX_S) return X_MAX_U;
        return v[PHY_WIDTH-1:0];
    endfunction

    function automatic logic [PHY_WIDTH-1:0] floor_y(input logic signed [AW-1:0] v);
        return (v < Y_FLOOR_S) ? Y_FLOOR_U : v[PHY_WIDTH-1:0];
    endfunction

    logic [1:0] left_sync, right_sync, jump_sync;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            left_sync  <= '0;
            right_sync <= '0;
            jump_sync  <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes the pre-edge value; blocking would merge both stages into one flop.
            left_sync  <= {left_sync[0], bus.left_btn};
            right_sync <= {right_sync[0], bus.right_btn};
            jump_sync  <= {jump_sync[0], bus.jump_btn};
        end
    end

    logic walk_l, walk_r, jump;
    assign walk_l = left_sync[1] & ~right_sync[1];
    assign walk_r = right_sync[1] & ~left_sync[1];
    assign jump   = jump_sync[1];

    state_t                 state, state_nxt;
    logic [PHY_WIDTH-1:0]   x, x_nxt, y, y_nxt;
    logic signed [VW-1:0]   vx, vx_nxt, vy, vy_nxt;
    logic                   face, face_nxt;
    logic [4:0]             charge, charge_nxt;

    logic signed [AW-1:0]   x_ext, x_sum, y_sum, walk_sum;
    logic signed [VW-1:0]   vy_grav;
    logic                   wall_hit, descending;

    assign x_ext      = signed'(AW'(x));
    assign x_sum      = x_ext + AW'(vx);
    assign y_sum      = signed'(AW'(y)) + AW'(vy);
    assign walk_sum   = walk_r ? x_ext + WALK_S : (walk_l ? x_ext - WALK_S : x_ext);
    assign wall_hit   = (x_sum < X_MIN_S) || (x_sum > X_MAX_S);
    assign descending = vy[VW-1] || (vy == '0);
    assign vy_grav    = vy - GRAV_S;

    always_comb begin
        // NOTE: every target gets its hold value first, so no path through the case can infer a latch.
        state_nxt  = state;
        x_nxt      = x;
        y_nxt      = y;
        vx_nxt     = vx;
        vy_nxt     = vy;
        face_nxt   = face;
        charge_nxt = charge;

        if (bus.game_tick) begin
            unique case (state)
                S_IDLE: begin
                    if (!bus.ground_hit && (y > Y_FLOOR_U)) begin
                        state_nxt = S_AIR;
                        vx_nxt    = '0;
                        vy_nxt    = '0;
                    end else if (jump) begin
                        state_nxt  = S_CHARGE;
                        charge_nxt = '0;
                    end else begin
                        x_nxt = clamp_x(walk_sum);
                        if (walk_l)      face_nxt = 1'b0;
                        else if (walk_r) face_nxt = 1'b1;
                    end
                end

                S_CHARGE: begin
                    if (walk_l)      face_nxt = 1'b0;
                    else if (walk_r) face_nxt = 1'b1;
                    if (jump) begin
                        if (charge != CHARGE_MAX) charge_nxt = charge + 5'd1;
                    end else begin
                        state_nxt  = S_AIR;
                        vy_nxt     = VY_MIN_S + signed'(VW'(charge));
                        vx_nxt     = walk_r ? JUMP_S : (walk_l ? -JUMP_S : '0);
                        charge_nxt = '0;
                    end
                end

                S_AIR: begin
                    x_nxt = clamp_x(x_sum);
                    // Landing outranks the wall response, which outranks gravity.
                    if (descending && (bus.ground_hit || (y_sum <= Y_FLOOR_S))) begin
                        state_nxt = S_LAND;
                        y_nxt     = floor_y(y_sum);
                        vx_nxt    = '0;
                        vy_nxt    = '0;
                    end else begin
                        if (wall_hit) begin
`ifdef CHAR_WALL_BOUNCE_EN
                            vx_nxt   = -vx;
                            face_nxt = ~face;
`else
                            vx_nxt   = '0;
`endif
                        end
                        y_nxt  = floor_y(y_sum);
                        vy_nxt = (vy_grav < FALL_LIM) ? FALL_LIM : vy_grav;
                    end
                end

                S_LAND: state_nxt = S_IDLE;

                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= S_IDLE;
            x      <= X_INIT_U;
            y      <= Y_FLOOR_U;
            vx     <= '0;
            vy     <= '0;
            face   <= 1'b1;
            charge <= '0;
        end else begin
            state  <= state_nxt;
            x      <= x_nxt;
            y      <= y_nxt;
            vx     <= vx_nxt;
            vy     <= vy_nxt;
            face   <= face_nxt;
            charge <= charge_nxt;
        end
    end

    assign bus.char_abs_x = x;
    assign bus.char_abs_y = y;
    assign bus.char_face  = face;
    assign bus.char_state = state;
    assign bus.charge_lvl = charge;
endmodule

// File: tb/tb_char_motion_ctrl.sv
// Self-checking bench for char_motion_ctrl: directed motion scenarios plus randomized ticks
// compared against an integer model of the motion rules.
module tb_char_motion_ctrl;
    localparam int X_MIN = 130, X_MAX = 550, X_INIT = 300, Y_FLOOR = 10;
    localparam int WALK = 2, JUMP_VX = 3, VY_MIN = 4, MAX_CHARGE = 31, MAX_FALL = 15;
`ifdef CHAR_WALL_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    char_motion_ctrl_if #(.PHY_WIDTH(14)) bus ();
    char_motion_ctrl dut (.sys_clk(clk), .sys_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int tests_run = 0;
    int failed    = 0;

    // Model state: plain integers following the motion rules.
    int m_x, m_y, m_vx, m_vy, m_face, m_state, m_charge;

    task automatic model_reset();
        m_x = X_INIT; m_y = Y_FLOOR; m_vx = 0; m_vy = 0;
        m_face = 1; m_state = 0; m_charge = 0;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_step(input bit l, input bit r, input bit j, input bit g);
        bit only_l = l && !r;
        bit only_r = r && !l;
        int nx, ny;
        case (m_state)
            0: begin
                if (!g && m_y > Y_FLOOR) begin
                    m_state = 2; m_vx = 0; m_vy = 0;
                end else if (j) begin
                    m_state = 1; m_charge = 0;
                end else if (only_l) begin
                    m_x = clampi(m_x - WALK, X_MIN, X_MAX); m_face = 0;
                end else if (only_r) begin
                    m_x = clampi(m_x + WALK, X_MIN, X_MAX); m_face = 1;
                end
            end
            1: begin
                if (only_l) m_face = 0;
                else if (only_r) m_face = 1;
                if (j) m_charge = (m_charge + 1 > MAX_CHARGE) ? MAX_CHARGE : m_charge + 1;
                else begin
                    m_state = 2;
                    m_vy = VY_MIN + m_charge;
                    m_vx = only_r ? JUMP_VX : (only_l ? -JUMP_VX : 0);
                    m_charge = 0;
                end
            end
            2: begin
                nx = m_x + m_vx;
                ny = m_y + m_vy;
                m_x = clampi(nx, X_MIN, X_MAX);
                if (m_vy <= 0 && (g || ny <= Y_FLOOR)) begin
                    m_y = (ny < Y_FLOOR) ? Y_FLOOR : ny;
                    m_vx = 0; m_vy = 0; m_state = 3;
                end else begin
                    if (nx < X_MIN || nx > X_MAX) begin
                        if (BOUNCE) begin m_vx = -m_vx; m_face = 1 - m_face; end
                        else m_vx = 0;
                    end
                    m_y = (ny < Y_FLOOR) ? Y_FLOOR : ny;
                    m_vy = (m_vy - 1 < -MAX_FALL) ? -MAX_FALL : m_vy - 1;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    function automatic logic [35:0] dut_snap();
        return {bus.char_abs_x, bus.char_abs_y, bus.char_face, bus.char_state, bus.charge_lvl};
    endfunction

    function automatic logic [35:0] model_snap();
        return {14'(m_x), 14'(m_y), 1'(m_face), 2'(m_state), 5'(m_charge)};
    endfunction

    function automatic string snap_str(input logic [35:0] s);
        return $sformatf("x=%0d y=%0d face=%0d state=%0d charge=%0d",
                         s[35:22], s[21:8], s[7], s[6:5], s[4:0]);
    endfunction

    // Buttons settle through the synchroniser before the one-cycle tick; outputs are sampled on a negedge.
    task automatic do_tick(input bit l, input bit r, input bit j, input bit g);
        @(negedge clk);
        bus.left_btn = l; bus.right_btn = r; bus.jump_btn = j; bus.ground_hit = g;
        repeat (2) @(negedge clk);
        bus.game_tick = 1'b1;
        @(negedge clk);
        bus.game_tick = 1'b0;
        model_step(l, r, j, g);
    endtask

    task automatic test_reset();
        logic [35:0] rst_exp = {14'd300, 14'd10, 1'b1, 2'd0, 5'd0};
        rst_n = 1'b0;
        bus.game_tick = 0; bus.left_btn = 0; bus.right_btn = 0; bus.jump_btn = 0; bus.ground_hit = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if (dut_snap() !== rst_exp) begin
            failed++; $display("FAIL reset_release got %s exp %s", snap_str(dut_snap()), snap_str(rst_exp));
        end
        do_tick(0, 0, 1, 0);
        do_tick(0, 0, 0, 0);
        do_tick(0, 0, 0, 0);
        tests_run++;
        if (dut_snap() !== model_snap() || bus.char_abs_y !== 14'd14) begin
            failed++; $display("FAIL reset_pre_air got %s exp %s", snap_str(dut_snap()), snap_str(model_snap()));
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (dut_snap() !== rst_exp) begin
            failed++; $display("FAIL reset_async_mid_air got %s exp %s", snap_str(dut_snap()), snap_str(rst_exp));
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_walk();
        for (int i = 0; i < 10; i++) do_tick(0, 1, 0, 0);
        tests_run++;
        if (bus.char_abs_x !== 14'd320 || bus.char_face !== 1'b1 || dut_snap() !== model_snap()) begin
            failed++; $display("FAIL walk_right got x=%0d face=%0d exp x=320 face=1", bus.char_abs_x, bus.char_face);
        end
        for (int i = 0; i < 5; i++) do_tick(1, 1, 0, 0);
        tests_run++;
        if (bus.char_abs_x !== 14'd320) begin
            failed++; $display("FAIL walk_both got x=%0d exp x=320", bus.char_abs_x);
        end
        do_tick(1, 0, 0, 0);
        tests_run++;
        if (bus.char_abs_x !== 14'd318 || bus.char_face !== 1'b0) begin
            failed++; $display("FAIL walk_left got x=%0d face=%0d exp x=318 face=0", bus.char_abs_x, bus.char_face);
        end
        do_tick(0, 1, 0, 0);
    endtask

    task automatic land_loop(input string name, input int budget);
        int n = 0;
        while (m_state != 0 && n < budget) begin
            do_tick(0, 0, 0, 0);
            n++;
            tests_run++;
            if (dut_snap() !== model_snap()) begin
                failed++; $display("FAIL %s_flight got %s exp %s", name, snap_str(dut_snap()), snap_str(model_snap()));
            end
        end
        tests_run++;
        if (n >= budget) begin
            failed++; $display("FAIL %s_timeout got state=%0d exp state=0", name, bus.char_state);
        end
    endtask

    task automatic test_charge_jump();
        for (int i = 0; i < 40; i++) do_tick(0, 0, 1, 0);
        tests_run++;
        if (bus.charge_lvl !== 5'd31 || bus.char_abs_x !== 14'd320 || bus.char_state !== 2'd1) begin
            failed++; $display("FAIL charge_saturate got charge=%0d x=%0d state=%0d exp charge=31 x=320 state=1",
                               bus.charge_lvl, bus.char_abs_x, bus.char_state);
        end
        do_tick(0, 1, 0, 0);
        tests_run++;
        if (bus.char_state !== 2'd2 || bus.char_face !== 1'b1 || bus.charge_lvl !== 5'd0) begin
            failed++; $display("FAIL charge_release got state=%0d face=%0d charge=%0d exp 2 1 0",
                               bus.char_state, bus.char_face, bus.charge_lvl);
        end
        do_tick(0, 0, 0, 0);
        tests_run++;
        if (bus.char_abs_y !== 14'd45 || bus.char_abs_x !== 14'd323) begin
            failed++; $display("FAIL charge_first_air got x=%0d y=%0d exp x=323 y=45", bus.char_abs_x, bus.char_abs_y);
        end
        land_loop("charge", 150);
    endtask

    task automatic test_zero_jump();
        int apex = 0;
        int n = 0;
        do_tick(0, 0, 1, 0);
        do_tick(0, 0, 0, 0);
        while (m_state != 3 && n < 30) begin
            do_tick(0, 0, 0, 0);
            n++;
            if (m_y > apex) apex = m_y;
            tests_run++;
            if (dut_snap() !== model_snap()) begin
                failed++; $display("FAIL zero_jump_flight got %s exp %s", snap_str(dut_snap()), snap_str(model_snap()));
            end
        end
        tests_run++;
        if (apex != 20 || bus.char_state !== 2'd3 || bus.char_abs_y !== 14'd10) begin
            failed++; $display("FAIL zero_jump_land got apex=%0d state=%0d y=%0d exp apex=20 state=3 y=10",
                               apex, bus.char_state, bus.char_abs_y);
        end
        do_tick(1, 0, 1, 0);
        tests_run++;
        if (bus.char_state !== 2'd0 || dut_snap() !== model_snap()) begin
            failed++; $display("FAIL land_to_idle got %s exp %s", snap_str(dut_snap()), snap_str(model_snap()));
        end
    endtask

    task automatic test_wall();
        for (int i = 0; i < 30; i++) do_tick(0, 1, 0, 0);
        do_tick(1, 0, 0, 0);
        tests_run++;
        if (bus.char_abs_x !== 14'd548) begin
            failed++; $display("FAIL wall_setup got x=%0d exp x=548", bus.char_abs_x);
        end
        do_tick(0, 0, 1, 0);
        do_tick(0, 1, 0, 0);
        do_tick(0, 0, 0, 0);
        tests_run++;
        if (bus.char_abs_x !== 14'd550 || bus.char_face !== (BOUNCE ? 1'b0 : 1'b1)) begin
            failed++; $display("FAIL wall_clamp got x=%0d face=%0d exp x=550 face=%0d",
                               bus.char_abs_x, bus.char_face, BOUNCE ? 0 : 1);
        end
        do_tick(0, 0, 0, 0);
        tests_run++;
        if (bus.char_abs_x !== (BOUNCE ? 14'd547 : 14'd550)) begin
            failed++; $display("FAIL wall_after got x=%0d exp x=%0d", bus.char_abs_x, BOUNCE ? 547 : 550);
        end
        land_loop("wall", 20);
    endtask

    task automatic test_ledge();
        int n = 0;
        int plat_y, exp_y;
        bit g;
        for (int i = 0; i < 40; i++) do_tick(0, 0, 1, 0);
        do_tick(0, 0, 0, 0);
        while (m_state != 3 && n < 200) begin
            g = (m_vy <= 0 && m_y <= 350);
            do_tick(0, 0, 0, g);
            n++;
        end
        tests_run++;
        if (bus.char_state !== 2'd3 || dut_snap() !== model_snap() || bus.char_abs_y <= 14'd200) begin
            failed++; $display("FAIL platform_land got %s exp %s", snap_str(dut_snap()), snap_str(model_snap()));
        end
        do_tick(0, 0, 0, 1);
        plat_y = m_y;
        do_tick(0, 0, 0, 0);
        tests_run++;
        if (bus.char_state !== 2'd2 || bus.char_abs_y !== 14'(plat_y)) begin
            failed++; $display("FAIL ledge_walk_off got state=%0d y=%0d exp state=2 y=%0d",
                               bus.char_state, bus.char_abs_y, plat_y);
        end
        exp_y = plat_y;
        for (int k = 0; k < 18; k++) begin
            do_tick(0, 0, 0, 0);
            exp_y -= (k < MAX_FALL) ? k : MAX_FALL;
        end
        tests_run++;
        if (bus.char_abs_y !== 14'(exp_y) || bus.char_state !== 2'd2) begin
            failed++; $display("FAIL ledge_terminal got y=%0d state=%0d exp y=%0d state=2",
                               bus.char_abs_y, bus.char_state, exp_y);
        end
        do_tick(0, 0, 0, 1);
        tests_run++;
        if (bus.char_abs_y !== 14'(exp_y - MAX_FALL) || bus.char_state !== 2'd3) begin
            failed++; $display("FAIL ledge_ground_land got y=%0d state=%0d exp y=%0d state=3",
                               bus.char_abs_y, bus.char_state, exp_y - MAX_FALL);
        end
        do_tick(0, 0, 0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bit l = ($urandom_range(0, 3) == 0);
            bit r = ($urandom_range(0, 3) == 0);
            bit j = ($urandom_range(0, 2) == 0);
            bit g = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                bus.left_btn = ~l; bus.right_btn = ~r; bus.jump_btn = ~j; bus.ground_hit = ~g;
                repeat (5) @(negedge clk);
                tests_run++;
                if (dut_snap() !== model_snap()) begin
                    failed++; $display("FAIL random_hold got %s exp %s", snap_str(dut_snap()), snap_str(model_snap()));
                end
            end
            do_tick(l, r, j, g);
            tests_run++;
            if (dut_snap() !== model_snap()) begin
                failed++; $display("FAIL random_tick%0d got %s exp %s", i, snap_str(dut_snap()), snap_str(model_snap()));
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_charge_jump();
        test_zero_jump();
        test_wall();
        test_ledge();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
